// File: rtl/core_pkg.sv
// Shared definitions for the segmented core: fetch state encoding and
// instruction-word constants used by the fetch stage and its pipeline register.
package core_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush (or reset) inserts a NOP bubble; hold freezes
// the current contents; otherwise a fetched word is captured as valid.
module if_id_reg
    import core_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] FLUSH_WORD = WIDTH'(NOP_WORD)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc4_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc4_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc4_q;
    logic             valid_q;

    // Flush outranks hold so a redirect during a stall still squashes.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            instr_q <= FLUSH_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALTED fetch control and the IF/ID
// register. The instruction memory is read combinationally from the current PC.
module if_stage #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 5,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] HALT_WORD = WIDTH'(core_pkg::HALT_WORD),
    parameter logic [WIDTH-1:0] NOP_WORD  = WIDTH'(core_pkg::NOP_WORD)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_rd_en_o,
    output logic [DEPTH-1:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_data_i,
    output logic [WIDTH-1:0] if_id_instr_o,
    output logic [WIDTH-1:0] if_id_pc4_o,
    output logic             if_id_valid_o,
    output logic             halted_o
);

    core_pkg::fetch_state_e state_q, state_d;
    logic [WIDTH-1:0]       pc_q, pc_d;
    logic [WIDTH-1:0]       pc_inc;
    logic                   hold, flush;

    assign pc_inc = pc_q + WIDTH'(core_pkg::PC_INC);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold    = 1'b0;
        flush   = 1'b1;
        if (state_q != core_pkg::BOOT && redirect_i) begin
            pc_d    = redirect_pc_i & ~WIDTH'(3);
            state_d = core_pkg::RUN;
        end else begin
            case (state_q)
                core_pkg::BOOT: state_d = core_pkg::RUN;
                core_pkg::RUN: begin
                    if (stall_i) begin
                        hold  = 1'b1;
                        flush = 1'b0;
                    end else if (imem_data_i == HALT_WORD) begin
                        state_d = core_pkg::HALTED;
                    end else begin
                        flush = 1'b0;
                        pc_d  = pc_inc;
                    end
                end
                core_pkg::HALTED: state_d = core_pkg::HALTED;
                default: state_d = core_pkg::BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            state_q <= core_pkg::BOOT;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign imem_rd_en_o = (state_q == core_pkg::RUN);
    assign halted_o     = (state_q == core_pkg::HALTED);
    assign imem_addr_o  = pc_q[DEPTH+1:2];

    if_id_reg #(
        .WIDTH      (WIDTH),
        .FLUSH_WORD (NOP_WORD)
    ) u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hold_i  (hold),
        .flush_i (flush),
        .instr_i (imem_data_i),
        .pc4_i   (pc_inc),
        .instr_o (if_id_instr_o),
        .pc4_o   (if_id_pc4_o),
        .valid_o (if_id_valid_o)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage against a behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        rd_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] instr, pc4;
    logic        valid, halted;

    logic [31:0] mem [32];

    int checks   = 0;
    int failures = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          m_st;

    always #5 clk = ~clk;

    assign data = mem[addr];

    if_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_rd_en_o  (rd_en),
        .imem_addr_o   (addr),
        .imem_data_i   (data),
        .if_id_instr_o (instr),
        .if_id_pc4_o   (pc4),
        .if_id_valid_o (valid),
        .halted_o      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies the stage rules for one clock edge to the model.
    task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        logic [31:0] word;
        word = mem[m_pc[6:2]];
        if (r) begin
            m_pc = 32'h0; m_st = M_BOOT; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        end else if (m_st == M_BOOT) begin
            m_st = M_RUN; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        end else if (rd) begin
            m_pc = {rpc[31:2], 2'b00}; m_st = M_RUN; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        end else if (m_st == M_RUN && s) begin
            // everything holds
        end else if (m_st == M_RUN && word == HALT) begin
            m_st = M_HALT; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        end else if (m_st == M_RUN) begin
            m_instr = word; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
        end else begin
            m_instr = NOP; m_pc4 = 0; m_valid = 0;
        end
    endtask

    task automatic check_all();
        chk("valid", {31'b0, valid}, {31'b0, m_valid});
        chk("instr", instr, m_instr);
        if (m_valid || m_st == M_BOOT) chk("pc4", pc4, m_pc4);
        chk("addr", {27'b0, addr}, {27'b0, m_pc[6:2]});
        chk("rd_en", {31'b0, rd_en}, {31'b0, (m_st == M_RUN)});
        chk("halted", {31'b0, halted}, {31'b0, (m_st == M_HALT)});
    endtask

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge(r, s, rd, rpc);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
        m_pc = 0; m_st = M_BOOT; m_instr = NOP; m_pc4 = 0; m_valid = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = HALT;
        mem[16] = 32'hABCD_0016; mem[31] = 32'h3131_3131;

        // reset state
        step(1, 1, 1, 32'h40);
        step(1, 0, 0, 0);
        chk("reset_instr", instr, NOP);
        chk("reset_pc4", pc4, 32'h0);

        // boot: redirect and stall ignored
        step(0, 1, 1, 32'h40);
        step(0, 0, 0, 0);
        chk("first_instr", instr, 32'h11);
        chk("first_pc4", pc4, 32'h4);
        step(0, 0, 0, 0);
        chk("second_instr", instr, 32'h22);

        // stall at pc=8 for three cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_addr", {27'b0, addr}, 32'd2);
            chk("stall_hold", instr, 32'h22);
        end
        step(0, 0, 0, 0);
        chk("resume_instr", instr, 32'h33);
        chk("resume_pc4", pc4, 32'd12);

        // halt word at word 3; stall ignored while halted
        step(0, 0, 0, 0);
        chk("halted_flag", {31'b0, halted}, 32'd1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // redirect with stall, low bits cleared
        step(0, 1, 1, 32'h0000_0043);
        chk("redir_addr", {27'b0, addr}, 32'd16);
        step(0, 0, 0, 0);
        chk("redir_tgt", instr, 32'hABCD_0016);
        chk("redir_pc4", pc4, 32'h44);

        // redirect in RUN while stalled
        step(0, 1, 1, 32'h0);
        step(0, 0, 0, 0);
        chk("restart_instr", instr, 32'h11);

        // wrap at 0x7C
        step(0, 0, 1, 32'h7C);
        step(0, 0, 0, 0);
        chk("wrap_pc4", pc4, 32'h80);
        chk("wrap_addr", {27'b0, addr}, 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        // reset while halted, then while stalled
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_stall_valid", {31'b0, valid}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // randomized phase
        for (int i = 0; i < 32; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom);
            if (n % 50 == 0) mem[$urandom_range(0, 31)] = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
